// File: rtl/cache_req_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_req_issuer_pkg
// Brief    : Shared types and default widths for the cache request issuer.
// Revision : 1.0 - initial release
// ============================================================================
package cache_req_issuer_pkg;

    localparam int c_ADDR_WIDTH = 14;
    localparam int c_DATA_WIDTH = 10;

    typedef struct packed {
        logic                    write;
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] wdata;
    } cache_req_t;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_ISSUE = 2'd1,
        ISS_RESP  = 2'd2
    } issuer_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_req_issuer_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : req_fifo
// Brief    : Wrap-around pointer request FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cache_req_issuer.sv
`default_nettype none
// ============================================================================
// Module   : cache_req_issuer
// Brief    : Queues host requests and issues them one at a time to the cache,
//            with held responses, hit/miss statistics and a timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cache_req_issuer
    import cache_req_issuer_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  hit,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_strob,
    input  logic                  ready,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);
    localparam int                 c_REQ_W    = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int                 c_TMO_W    = $clog2(TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    issuer_state_e          r_state,  w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr,   w_addr_nxt;
    logic                   r_read,   w_read_nxt;
    logic                   r_write,  w_write_nxt;
    logic [DATA_WIDTH-1:0]  r_wdata,  w_wdata_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic                   r_rsp_write, w_rsp_write_nxt;
    logic [DATA_WIDTH-1:0]  r_rsp_data,  w_rsp_data_nxt;
    logic                   r_rsp_hit,   w_rsp_hit_nxt;
    logic                   r_rsp_err,   w_rsp_err_nxt;
    logic [c_TMO_W-1:0]     r_tmo_cnt,   w_tmo_nxt;
    logic [CNT_WIDTH-1:0]   r_hit_cnt,   w_hit_cnt_nxt;
    logic [CNT_WIDTH-1:0]   r_miss_cnt,  w_miss_cnt_nxt;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_fifo_pop;
    logic [c_REQ_W-1:0]     w_head;

    req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_REQ_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data ({req_write, req_addr, req_wdata}),
        .pop       (w_fifo_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign req_ready  = ~w_full;
    assign addr       = r_addr;
    assign read       = r_read;
    assign write      = r_write;
    assign write_data = r_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_write  = r_rsp_write;
    assign rsp_data   = r_rsp_data;
    assign rsp_hit    = r_rsp_hit;
    assign rsp_err    = r_rsp_err;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_read_nxt      = r_read;
        w_write_nxt     = r_write;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_hit_nxt   = r_rsp_hit;
        w_rsp_err_nxt   = r_rsp_err;
        w_tmo_nxt       = r_tmo_cnt;
        w_hit_cnt_nxt   = r_hit_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_fifo_pop      = 1'b0;

        case (r_state)
            ISS_IDLE: begin
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                if (!w_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_write_nxt = w_head[c_REQ_W-1];
                    w_read_nxt  = ~w_head[c_REQ_W-1];
                    w_addr_nxt  = w_head[DATA_WIDTH +: ADDR_WIDTH];
                    w_wdata_nxt = w_head[DATA_WIDTH-1:0];
                    w_tmo_nxt   = '0;
                    w_state_nxt = ISS_ISSUE;
                end
            end
            ISS_ISSUE: begin
                w_tmo_nxt = r_tmo_cnt + 1'b1;
                // A completion arriving on the final watchdog cycle still counts as success.
                if (ready) begin
                    w_read_nxt      = 1'b0;
                    w_write_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_write;
                    w_rsp_data_nxt  = data_strob ? data : '0;
                    w_rsp_hit_nxt   = hit;
                    w_rsp_err_nxt   = 1'b0;
                    if (hit) begin
                        if (r_hit_cnt != '1) w_hit_cnt_nxt = r_hit_cnt + 1'b1;
                    end else begin
                        if (r_miss_cnt != '1) w_miss_cnt_nxt = r_miss_cnt + 1'b1;
                    end
                    w_state_nxt = ISS_RESP;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_read_nxt      = 1'b0;
                    w_write_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_write;
                    w_rsp_data_nxt  = '0;
                    w_rsp_hit_nxt   = 1'b0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = ISS_RESP;
                end
            end
            ISS_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ISS_IDLE;
                end
            end
            default: begin
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                w_state_nxt = ISS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ISS_IDLE;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_tmo_cnt   <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_hit   <= w_rsp_hit_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_hit_cnt   <= w_hit_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
